// File: rtl/shape_processor_ctrl.sv
// ---------------------------------------------------------------------------
// shape_processor_ctrl
//   Per-channel CTRL register bank for the shape processor. Writes go through
//   field legality checks, KEEP resolution and shape/operation compatibility
//   checks. An accepted write leaves a pending command for its channel.
//   Pending commands are handed to the datapath through a round-robin
//   arbitrated valid/ready port.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   write_i          write strobe
//   read_i           read strobe
//   addr_i           channel index of the access
//   wdata_i          {14'rsvd, SHAPE[1:0], 10'rsvd, OPERATION[5:0]}
//   rdata_o          registered read data, same layout, holds until next read
//   wr_err_o         one-cycle pulse after a rejected write
//   cmd_valid_o      command presented to the datapath
//   cmd_ready_i      datapath accepts the presented command
//   cmd_channel_o    source channel of the presented command
//   cmd_shape_o      shape code of the presented command
//   cmd_operation_o  operation code of the presented command
//
// Arbiter states
//   state    | meaning
//   ---------+------------------------------------------------------
//   IDLE     | nothing presented; grab the next pending channel
//   PRESENT  | cmd_* valid and held until cmd_ready_i
// ---------------------------------------------------------------------------
module shape_processor_ctrl #(
  parameter int NUM_CHANNELS = 4,
  localparam int ADDR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              write_i,
  input  logic              read_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              wr_err_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_channel_o,
  output logic [1:0]        cmd_shape_o,
  output logic [5:0]        cmd_operation_o
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  localparam logic [1:0] SH_RECT = 2'b01;
  localparam logic [1:0] SH_TRI  = 2'b10;
  localparam logic [1:0] SH_KEEP = 2'b11;

  localparam logic [5:0] OP_PERIM = 6'b000000;
  localparam logic [5:0] OP_AREA  = 6'b000001;
  localparam logic [5:0] OP_SQ    = 6'b010000;
  localparam logic [5:0] OP_EQUI  = 6'b100000;
  localparam logic [5:0] OP_ISO   = 6'b100001;
  localparam logic [5:0] OP_KEEP  = 6'b111111;

  localparam logic [ADDR_W:0]   NUM_CH_L  = (ADDR_W+1)'(NUM_CHANNELS);
  localparam logic [ADDR_W-1:0] PTR_RESET = ADDR_W'(NUM_CHANNELS - 1);

  logic [1:0]              shape_q [NUM_CHANNELS];
  logic [5:0]              op_q    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending_q, pending_d;
  logic [0:0]              state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    wr_err_q;
  logic [ADDR_W-1:0]       cmd_channel_q, cmd_channel_d;
  logic [1:0]              cmd_shape_q, cmd_shape_d;
  logic [5:0]              cmd_op_q, cmd_op_d;

  logic       addr_ok;
  logic [1:0] cur_shape;
  logic [5:0] cur_op;
  logic [1:0] new_shape;
  logic [5:0] new_op;
  logic       wr_accept;
  logic       wr_reject;

  logic              grant_found;
  logic [ADDR_W-1:0] grant_idx;
  logic              capture;

  // Reserved wdata bits carry no meaning.
  logic unused_wdata;
  assign unused_wdata = ^{wdata_i[31:18], wdata_i[15:6]};

  assign addr_ok = ({1'b0, addr_i} < NUM_CH_L);

  always_comb begin
    cur_shape = SH_RECT;
    cur_op    = OP_PERIM;
    if (addr_ok) begin
      cur_shape = shape_q[addr_i];
      cur_op    = op_q[addr_i];
    end
  end

  // Write qualification: range, raw field legality, KEEP resolution, combo.
  always_comb begin
    logic raw_ok;
    logic combo_ok;
    new_shape = (wdata_i[17:16] == SH_KEEP) ? cur_shape : wdata_i[17:16];
    new_op    = (wdata_i[5:0] == OP_KEEP) ? cur_op : wdata_i[5:0];
    raw_ok    = (wdata_i[17:16] != 2'b00) &&
                (wdata_i[5:0] == OP_PERIM || wdata_i[5:0] == OP_AREA ||
                 wdata_i[5:0] == OP_SQ    || wdata_i[5:0] == OP_EQUI ||
                 wdata_i[5:0] == OP_ISO   || wdata_i[5:0] == OP_KEEP);
    combo_ok  = 1'b0;
    case (new_op)
      OP_PERIM, OP_AREA: combo_ok = 1'b1;
      OP_SQ:             combo_ok = (new_shape == SH_RECT);
      OP_EQUI, OP_ISO:   combo_ok = (new_shape == SH_TRI);
      default:           combo_ok = 1'b0;
    endcase
    wr_accept = write_i && addr_ok && raw_ok && combo_ok;
    wr_reject = write_i && !wr_accept;
  end

  // First pending channel strictly after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_CHANNELS;
      if (!grant_found && pending_q[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ADDR_W'(idx);
      end
    end
  end

  assign capture = grant_found && ((state_q == ST_IDLE) || cmd_ready_i);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cmd_channel_d = cmd_channel_q;
    cmd_shape_d   = cmd_shape_q;
    cmd_op_d      = cmd_op_q;
    pending_d     = pending_q;

    if (capture) begin
      state_d              = ST_PRESENT;
      ptr_d                = grant_idx;
      cmd_channel_d        = grant_idx;
      cmd_shape_d          = shape_q[grant_idx];
      cmd_op_d             = op_q[grant_idx];
      pending_d[grant_idx] = 1'b0;
    end else if (state_q == ST_PRESENT && cmd_ready_i) begin
      state_d = ST_IDLE;
    end

    // Applied after the capture clear so a same-edge write re-arms the channel.
    if (wr_accept) begin
      pending_d[addr_i] = 1'b1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (read_i) begin
      rdata_d = addr_ok ? {14'b0, cur_shape, 10'b0, cur_op} : 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shape_q[i] <= SH_RECT;
        op_q[i]    <= OP_PERIM;
      end
      pending_q     <= '0;
      state_q       <= ST_IDLE;
      ptr_q         <= PTR_RESET;
      rdata_q       <= '0;
      wr_err_q      <= 1'b0;
      cmd_channel_q <= '0;
      cmd_shape_q   <= '0;
      cmd_op_q      <= '0;
    end else begin
      if (wr_accept) begin
        shape_q[addr_i] <= new_shape;
        op_q[addr_i]    <= new_op;
      end
      pending_q     <= pending_d;
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      rdata_q       <= rdata_d;
      wr_err_q      <= wr_reject;
      cmd_channel_q <= cmd_channel_d;
      cmd_shape_q   <= cmd_shape_d;
      cmd_op_q      <= cmd_op_d;
    end
  end

  assign rdata_o         = rdata_q;
  assign wr_err_o        = wr_err_q;
  assign cmd_valid_o     = (state_q == ST_PRESENT);
  assign cmd_channel_o   = cmd_channel_q;
  assign cmd_shape_o     = cmd_shape_q;
  assign cmd_operation_o = cmd_op_q;

endmodule

// File: tb/tb_shape_processor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shape_processor_ctrl
//   Directed bench for shape_processor_ctrl with four channels. A behavioural
//   model (register arrays, pending flags, rotating pointer) predicts every
//   output and is compared on each falling edge; literal expectations on
//   reads and on the accepted-command log pin the model itself.
// ---------------------------------------------------------------------------
module tb_shape_processor_ctrl;

  localparam int NCH = 4;

  logic        clk;
  logic        rst;
  logic        write;
  logic        read;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wr_err;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_channel;
  logic [1:0]  cmd_shape;
  logic [5:0]  cmd_operation;

  shape_processor_ctrl #(.NUM_CHANNELS(NCH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .write_i         (write),
    .read_i          (read),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .rdata_o         (rdata),
    .wr_err_o        (wr_err),
    .cmd_valid_o     (cmd_valid),
    .cmd_ready_i     (cmd_ready),
    .cmd_channel_o   (cmd_channel),
    .cmd_shape_o     (cmd_shape),
    .cmd_operation_o (cmd_operation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0]  m_shape [NCH];
  logic [5:0]  m_op    [NCH];
  bit          m_pend  [NCH];
  int          m_ptr;
  bit          m_valid;
  int          m_ch;
  logic [1:0]  m_cs;
  logic [5:0]  m_co;
  logic [31:0] m_rdata;
  bit          m_err;

  function automatic bit shape_ok(input logic [1:0] s);
    return s != 2'b00;
  endfunction

  function automatic bit op_ok(input logic [5:0] o);
    return o == 6'd0 || o == 6'd1 || o == 6'd16 || o == 6'd32 || o == 6'd33 || o == 6'd63;
  endfunction

  function automatic bit combo_ok(input logic [1:0] s, input logic [5:0] o);
    if (o == 6'd0 || o == 6'd1) return 1'b1;
    if (o == 6'd16) return s == 2'b01;
    if (o == 6'd32 || o == 6'd33) return s == 2'b10;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_shape[i] = 2'b01;
        m_op[i]    = 6'd0;
        m_pend[i]  = 1'b0;
      end
      m_ptr = NCH - 1; m_valid = 0; m_ch = 0; m_cs = 0; m_co = 0;
      m_rdata = 0; m_err = 0;
    end else begin
      int a;
      bit acc;
      bit found;
      logic [1:0] ns;
      logic [5:0] no;
      a = int'(addr);
      acc = 0;
      m_err = 0;
      ns = wdata[17:16];
      no = wdata[5:0];
      if (write) begin
        if (a >= NCH || !shape_ok(ns) || !op_ok(no)) m_err = 1;
        else begin
          if (ns == 2'b11) ns = m_shape[a];
          if (no == 6'h3f) no = m_op[a];
          if (combo_ok(ns, no)) acc = 1; else m_err = 1;
        end
      end
      if (read) m_rdata = (a < NCH) ? {14'b0, m_shape[a], 10'b0, m_op[a]} : 32'h0;
      if (!m_valid || cmd_ready) begin
        found = 0;
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_ptr + k) % NCH;
          if (!found && m_pend[c]) begin
            found = 1;
            m_pend[c] = 0;
            m_ptr = c;
            m_ch = c;
            m_cs = m_shape[c];
            m_co = m_op[c];
          end
        end
        m_valid = found;
      end
      if (acc) begin
        m_shape[a] = ns;
        m_op[a]    = no;
        m_pend[a]  = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    cmp("cmd_valid", {31'b0, cmd_valid}, {31'b0, m_valid});
    cmp("wr_err", {31'b0, wr_err}, {31'b0, m_err});
    cmp("rdata", rdata, m_rdata);
    if (m_valid) begin
      cmp("cmd_channel", {30'b0, cmd_channel}, 32'(m_ch));
      cmp("cmd_shape", {30'b0, cmd_shape}, {30'b0, m_cs});
      cmp("cmd_operation", {26'b0, cmd_operation}, {26'b0, m_co});
    end
  end

  // ---------------- accepted-command log ----------------
  int         cyc = 0;
  int         hs_ch  [$];
  logic [7:0] hs_cmd [$];
  int         hs_cyc [$];

  always @(posedge clk) begin
    cyc++;
    if (!rst && cmd_valid && cmd_ready) begin
      hs_ch.push_back(int'(cmd_channel));
      hs_cmd.push_back({cmd_shape, cmd_operation});
      hs_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    write = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    read = 1'b1; addr = a;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic chk_hs(input string nm, input int idx, input int ch, input logic [7:0] c);
    cmp({nm, "_ch"}, 32'(hs_ch[idx]), 32'(ch));
    cmp({nm, "_cmd"}, {24'b0, hs_cmd[idx]}, {24'b0, c});
  endtask

  initial begin
    int n0;
    rst = 1'b1; write = 0; read = 0; addr = 0; wdata = 0; cmd_ready = 0;
    tick(3);
    rst = 1'b0;

    // Reset values of every channel
    for (int i = 0; i < NCH; i++) begin
      rd(2'(i));
      cmp("reset_read", rdata, 32'h0001_0000);
    end
    cmp("reset_valid", {31'b0, cmd_valid}, 32'd0);
    cmp("reset_err", {31'b0, wr_err}, 32'd0);

    // Triangle / isosceles on ch1, held until ready
    n0 = hs_ch.size();
    wr(2'd1, 32'h0002_0021);
    cmp("lat_e0_valid", {31'b0, cmd_valid}, 32'd0);
    tick(1);
    cmp("lat_e1_valid", {31'b0, cmd_valid}, 32'd1);
    cmp("ch1_cmd_channel", {30'b0, cmd_channel}, 32'd1);
    cmp("ch1_cmd_shape", {30'b0, cmd_shape}, 32'd2);
    cmp("ch1_cmd_op", {26'b0, cmd_operation}, 32'h21);
    tick(3);
    cmp("ch1_hold_valid", {31'b0, cmd_valid}, 32'd1);
    cmp("ch1_hold_op", {26'b0, cmd_operation}, 32'h21);
    cmd_ready = 1; tick(1); cmd_ready = 0;
    cmp("ch1_hs_count", 32'(hs_ch.size() - n0), 32'd1);
    chk_hs("ch1_hs", n0, 1, 8'h A1);
    rd(2'd1);
    cmp("ch1_read", rdata, 32'h0002_0021);

    // KEEP shape + IS_SQUARE on ch0, then an illegal combo
    wr(2'd0, 32'h0003_0010);
    cmd_ready = 1; tick(2); cmd_ready = 0;
    n0 = hs_ch.size();
    wr(2'd0, 32'h0002_0010);
    cmp("combo_err_pulse", {31'b0, wr_err}, 32'd1);
    tick(1);
    cmp("combo_err_clear", {31'b0, wr_err}, 32'd0);
    rd(2'd0);
    cmp("ch0_after_reject", rdata, 32'h0001_0010);
    tick(2);
    cmp("no_cmd_after_reject", 32'(hs_ch.size() - n0) | {31'b0, cmd_valid}, 32'd0);

    // Illegal raw fields on ch2
    wr(2'd2, 32'h0000_0000);
    cmp("shape00_err", {31'b0, wr_err}, 32'd1);
    wr(2'd2, 32'h0001_0002);
    cmp("op02_err", {31'b0, wr_err}, 32'd1);
    rd(2'd2);
    cmp("ch2_unchanged", rdata, 32'h0001_0000);
    cmp("ch2_no_pending", {31'b0, cmd_valid}, 32'd0);

    // Reserved bits ignored
    wr(2'd3, 32'hFFFD_FFC1);
    cmd_ready = 1; tick(2); cmd_ready = 0;
    rd(2'd3);
    cmp("reserved_ignored", rdata, 32'h0001_0001);

    // Back-to-back issue 0,1,3 with ready held high
    cmd_ready = 1;
    n0 = hs_ch.size();
    wr(2'd0, 32'h0001_0001);
    wr(2'd1, 32'h0002_0000);
    wr(2'd3, 32'h0001_0010);
    tick(4);
    cmd_ready = 0;
    cmp("b2b_count", 32'(hs_ch.size() - n0), 32'd3);
    chk_hs("b2b_0", n0, 0, 8'h41);
    chk_hs("b2b_1", n0 + 1, 1, 8'h80);
    chk_hs("b2b_2", n0 + 2, 3, 8'h50);
    cmp("b2b_gap01", 32'(hs_cyc[n0 + 1] - hs_cyc[n0]), 32'd1);
    cmp("b2b_gap12", 32'(hs_cyc[n0 + 2] - hs_cyc[n0 + 1]), 32'd1);

    // Round-robin rotation with all channels pending
    n0 = hs_ch.size();
    for (int i = 0; i < NCH; i++) wr(2'(i), 32'h0003_003F);
    wr(2'd0, 32'h0003_003F);
    for (int i = 0; i < 5; i++) begin
      cmd_ready = 1; tick(1); cmd_ready = 0; tick(1);
    end
    cmp("rr_count", 32'(hs_ch.size() - n0), 32'd5);
    cmp("rr_0", 32'(hs_ch[n0]), 32'd0);
    cmp("rr_1", 32'(hs_ch[n0 + 1]), 32'd1);
    cmp("rr_2", 32'(hs_ch[n0 + 2]), 32'd2);
    cmp("rr_3", 32'(hs_ch[n0 + 3]), 32'd3);
    cmp("rr_4", 32'(hs_ch[n0 + 4]), 32'd0);

    // Rewrite of a presented channel
    n0 = hs_ch.size();
    wr(2'd2, 32'h0002_0000);
    tick(1);
    wr(2'd2, 32'h0002_0020);
    tick(2);
    cmp("held_channel", {30'b0, cmd_channel}, 32'd2);
    cmp("held_op", {26'b0, cmd_operation}, 32'h00);
    cmd_ready = 1; tick(2); cmd_ready = 0;
    cmp("rewrite_count", 32'(hs_ch.size() - n0), 32'd2);
    chk_hs("rewrite_old", n0, 2, 8'h80);
    chk_hs("rewrite_new", n0 + 1, 2, 8'hA0);

    // Write landing on the capture edge of the same channel
    n0 = hs_ch.size();
    cmd_ready = 1;
    wr(2'd1, 32'h0001_0001);
    wr(2'd1, 32'h0001_0010);
    tick(3);
    cmd_ready = 0;
    cmp("samedge_count", 32'(hs_ch.size() - n0), 32'd2);
    chk_hs("samedge_old", n0, 1, 8'h41);
    chk_hs("samedge_new", n0 + 1, 1, 8'h50);

    // Coalescing while the arbiter is busy
    n0 = hs_ch.size();
    wr(2'd0, 32'h0003_003F);
    tick(1);
    wr(2'd3, 32'h0001_0001);
    wr(2'd3, 32'h0001_0010);
    cmd_ready = 1; tick(3); cmd_ready = 0;
    cmp("coalesce_count", 32'(hs_ch.size() - n0), 32'd2);
    chk_hs("coalesce_cmd", n0 + 1, 3, 8'h50);

    // Reset while presenting
    wr(2'd2, 32'h0002_0021);
    tick(1);
    cmp("pre_rst_valid", {31'b0, cmd_valid}, 32'd1);
    rst = 1; tick(1); rst = 0;
    cmp("rst_valid", {31'b0, cmd_valid}, 32'd0);
    cmp("rst_rdata", rdata, 32'd0);
    for (int i = 0; i < NCH; i++) begin
      rd(2'(i));
      cmp("post_rst_read", rdata, 32'h0001_0000);
    end
    tick(3);
    cmp("post_rst_idle", {31'b0, cmd_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shape_processor_ctrl.md
Name: shape_processor_ctrl

Overview:
Multi-channel control-register front end for the shape processor. It holds one CTRL SFR per channel and applies KEEP-field semantics on writes. Writes with illegal field values or illegal shape/operation combinations are rejected with an error pulse. Each accepted write becomes a pending command, and pending commands are issued to the processing datapath through a round-robin arbitrated valid/ready port.

Parameters:
NUM_CHANNELS, 4, number of independent CTRL SFRs/command sources (1..16)
ADDR_W, max(1,$clog2(NUM_CHANNELS)), width of the word address (derived; not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
write  input  1  write strobe, sampled on rising clk
read  input  1  read strobe, sampled on rising clk
addr  input  ADDR_W  channel index of the access
wdata  input  32  write data in CTRL layout: [31:18] reserved, [17:16] SHAPE, [15:6] reserved, [5:0] OPERATION
rdata  output  32  read data, registered
wr_err  output  1  one-cycle pulse flagging a rejected write
cmd_valid  output  1  command available
cmd_ready  input  1  datapath accepts command
cmd_channel  output  ADDR_W  source channel of the command
cmd_shape  output  2  shape code of the command
cmd_operation  output  6  operation code of the command

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values:
  - Every channel: SHAPE=RECTANGLE(01), OPERATION=PERIMETER(000000), pending=0.
  - Outputs: rdata=0, wr_err=0, cmd_valid=0, cmd_channel=0, cmd_shape=0, cmd_operation=0.
  - Round-robin pointer = NUM_CHANNELS-1, so channel 0 has first priority.
  - Arbiter state = IDLE.
  - Reset overrides any access or handshake in the same cycle.
- Legal encodings:
  - Shape: RECTANGLE=01, TRIANGLE=10, KEEP=11.
  - Operation: PERIMETER=000000, AREA=000001, IS_SQUARE=010000, IS_EQUILATERAL=100000, IS_ISOSCELES=100001, KEEP=111111.
- Write processing, in order:
  - a) addr>=NUM_CHANNELS -> reject.
  - b) Either raw field illegal (e.g. SHAPE=00) -> reject.
  - c) Resolve KEEP: a field equal to KEEP takes the channel's current value.
  - d) Check the resolved combination:
    - PERIMETER/AREA are legal with any shape.
    - IS_SQUARE is legal only with RECTANGLE.
    - IS_EQUILATERAL/IS_ISOSCELES are legal only with TRIANGLE.
    - Anything else -> reject.
  - e) Accept: update both fields and set pending[addr].
- Write timing and side effects:
  - Register and pending update at the sampling edge.
  - A reject leaves all state unchanged and asserts wr_err for exactly the following cycle.
  - An all-KEEP write is legal: the register is unchanged, but pending is still set.
  - Reserved wdata bits are ignored.
- Read:
  - rdata is valid the cycle after read is sampled: {14'b0, SHAPE, 10'b0, OPERATION}.
  - An out-of-range addr reads 0.
  - rdata holds its value until the next read.
  - Read and write to the same addr in the same cycle: read returns the pre-write value.
- Arbiter FSM, IDLE/PRESENT:
  - IDLE: if any pending bit is set, grant the first pending channel after the pointer (wrapping). Load cmd_* from that channel's register, clear its pending bit, move the pointer to the grant, and enter PRESENT (cmd_valid=1 next cycle).
  - PRESENT: cmd_* are held stable while cmd_valid=1 and cmd_ready=0.
  - PRESENT with cmd_ready=1: if another command is pending, load it in the same edge, giving back-to-back valid with no bubble. Otherwise go to IDLE with cmd_valid=0.
- Latency: write accepted at edge E0 with the arbiter idle -> cmd_valid high after E1.
- Edge cases:
  - A write and a capture on the same channel at the same edge: the capture takes the old value, and pending stays set (the write wins). The new value is issued later.
  - Repeated writes to a channel before capture coalesce into one command carrying the latest value.
  - A rejected write never sets pending.

Test Plan:
- Reset, then read each channel -> rdata=0x0001_0000 for all; cmd_valid=0; wr_err=0.
- Write ch1 wdata=0x0002_0021 (TRIANGLE, IS_ISOSCELES) -> cmd_valid after 2 edges, cmd_channel=1, shape=10, op=100001; held until cmd_ready; read ch1 = 0x0002_0021.
- Write ch0 SHAPE=KEEP, OP=IS_SQUARE (0x0003_0010) -> accepted (RECTANGLE kept). Then write ch0 0x0002_0010 (TRIANGLE+IS_SQUARE) -> wr_err one-cycle pulse, ch0 still 0x0001_0010, no extra command.
- Write illegal SHAPE=00 and illegal OP=000010 to ch2 -> wr_err each time; ch2 unchanged; no pending.
- With cmd_ready=1, write ch0, ch1, ch3 on consecutive cycles -> commands issued 0,1,3 back-to-back with no bubble. With cmd_ready held low, pend all channels -> grant order rotates 0,1,2,3,0.
- Hold cmd_ready=0 with ch2 presented and write a new value to ch2 -> presented command unchanged; after acceptance, a second ch2 command carries the new value. Assert rst mid-PRESENT -> cmd_valid=0 next cycle, all registers at reset values.
